// File: rtl/dma_capture_fifo.sv
// Capture FIFO between the sample stream and DMA_manager: circular buffer,
// threshold-driven fifo_full, registered read port, sticky overflow status.
// Optional: define DMA_CAPTURE_FIFO_DROP_COUNT_EN for a saturating 16-bit drop_count output.
module dma_capture_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int THRESHOLD  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic                       flush,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fill_level,
`ifdef DMA_CAPTURE_FIFO_DROP_COUNT_EN
  output logic [15:0]                drop_count,
`endif
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  wr_acc, rd_acc, drop;

  // flush wins over any transfer in the same cycle
  assign wr_acc = in_valid && in_ready && !flush;
  assign drop   = in_valid && !in_ready && !flush;
  assign rd_acc = rd_en && (count != '0) && !flush;

  always_comb begin
    count_next = count;
    if (wr_acc) count_next = count_next + CW'(1);
    if (rd_acc) count_next = count_next - CW'(1);
  end

  // storage is not reset; only pointers define validity
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      rd_valid  <= 1'b0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      if (drop) overflow <= 1'b1;
      rd_valid  <= rd_acc;
      count     <= count_next;
      in_ready  <= count_next < CW'(DEPTH);
      fifo_full <= count_next >= CW'(THRESHOLD);
    end
  end

  assign fill_level = count;

`ifdef DMA_CAPTURE_FIFO_DROP_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              drop_count <= '0;
    else if (flush)                          drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dma_capture_fifo.sv
// Directed bench for dma_capture_fifo (DEPTH=16, THRESHOLD=8) with hand-derived expectations.
module tb_dma_capture_fifo;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_ready, rd_en, rd_valid, flush, fifo_full, overflow;
  logic [31:0] rd_data;
  logic [4:0]  fill_level;
`ifdef DMA_CAPTURE_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  dma_capture_fifo #(.DATA_WIDTH(32), .DEPTH(16), .THRESHOLD(8)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .fifo_full(fifo_full), .fill_level(fill_level),
`ifdef DMA_CAPTURE_FIFO_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_data = '0; in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_full", 32'(fifo_full), 0);

    // fill to 16; fifo_full appears with the 8th word
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i);
      tick();
      check("fill_level", 32'(fill_level), 32'(i + 1));
      check("fill_full", 32'(fifo_full), (i + 1 >= 8) ? 32'd1 : 32'd0);
    end
    check("full_in_ready", 32'(in_ready), 0);
    check("no_ovf_yet", 32'(overflow), 0);
    in_data = 32'hDEAD;
    repeat (3) tick();
    in_valid = 1'b0;
    check("drop_overflow", 32'(overflow), 1);
    check("drop_fill", 32'(fill_level), 16);
    check("drop_in_ready", 32'(in_ready), 0);
`ifdef DMA_CAPTURE_FIFO_DROP_COUNT_EN
    check("drop_count", 32'(drop_count), 3);
`endif

    // drain all 16 plus one read at empty
    rd_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("drain_valid", 32'(rd_valid), 1);
      check("drain_data", rd_data, 32'h100 + 32'(k - 1));
      check("drain_fill", 32'(fill_level), 32'(16 - k));
      check("drain_full", 32'(fifo_full), (16 - k >= 8) ? 32'd1 : 32'd0);
    end
    tick();
    rd_en = 1'b0;
    check("empty_rd_valid", 32'(rd_valid), 0);
    check("empty_rd_hold", rd_data, 32'h10F);
    check("empty_fill", 32'(fill_level), 0);
    check("empty_in_ready", 32'(in_ready), 1);

    // 10 words with overflow still set, then flush with competing write/read
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h300 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre_flush_fill", 32'(fill_level), 10);
    check("pre_flush_full", 32'(fifo_full), 1);
    check("pre_flush_ovf", 32'(overflow), 1);
    flush = 1'b1; in_valid = 1'b1; rd_en = 1'b1; in_data = 32'hBAD;
    tick();
    flush = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    check("flush_fill", 32'(fill_level), 0);
    check("flush_full", 32'(fifo_full), 0);
    check("flush_ovf", 32'(overflow), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    check("flush_rd_valid", 32'(rd_valid), 0);
`ifdef DMA_CAPTURE_FIFO_DROP_COUNT_EN
    check("flush_drop_count", 32'(drop_count), 0);
`endif

    // write+read at empty: write taken, read ignored
    in_valid = 1'b1; rd_en = 1'b1; in_data = 32'h1FF;
    tick();
    check("empty_wr_rd_valid", 32'(rd_valid), 0);
    check("empty_wr_rd_fill", 32'(fill_level), 1);
    // streaming 40 cycles, one word in flight, pointers wrap
    for (int i = 0; i < 40; i++) begin
      in_data = 32'h200 + 32'(i);
      tick();
      check("stream_valid", 32'(rd_valid), 1);
      check("stream_data", rd_data, (i == 0) ? 32'h1FF : 32'h200 + 32'(i - 1));
      check("stream_fill", 32'(fill_level), 1);
      check("stream_ovf", 32'(overflow), 0);
    end
    in_valid = 1'b0;
    tick();
    rd_en = 1'b0;
    check("stream_last", rd_data, 32'h227);
    check("stream_end_fill", 32'(fill_level), 0);

    // async reset with a read in flight
    in_valid = 1'b1; in_data = 32'h400;
    repeat (2) tick();
    in_valid = 1'b0; rd_en = 1'b1;
    tick();
    check("pre_rst_rd_valid", 32'(rd_valid), 1);
    reset = 1'b0;
    #1;
    check("midrst_rd_valid", 32'(rd_valid), 0);
    check("midrst_fill", 32'(fill_level), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_rd_data", rd_data, 0);
    rd_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rerelease_in_ready", 32'(in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
